// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register.
// Emits one window per sampled pixel once two full rows and two columns are available.
module window_3x3_gen #(
  parameter int WIDTH  = 30,
  parameter int HEIGHT = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  grayscale_i,
  input  logic        done_i,
  output logic [71:0] window_o,
  output logic        valid_o,
  output logic        frame_done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Position of the next pixel to be sampled
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Previous two image rows, addressed by column
  logic [7:0] r_lb1 [WIDTH];
  logic [7:0] r_lb2 [WIDTH];

  // Window rows, oldest column in the upper byte
  logic [23:0] r_top;
  logic [23:0] r_mid;
  logic [23:0] r_bot;

  logic [71:0] r_window;
  logic        r_valid;
  logic        r_frame_done;

  logic        w_sample;
  logic        w_col_last;
  logic        w_row_last;
  logic        w_win_ok;
  logic [7:0]  w_lb1_q;
  logic [7:0]  w_lb2_q;
  logic [23:0] w_top_next;
  logic [23:0] w_mid_next;
  logic [23:0] w_bot_next;

  assign w_sample   = done_i;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_win_ok   = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  assign w_lb1_q = r_lb1[r_col];
  assign w_lb2_q = r_lb2[r_col];

  assign w_top_next = {r_top[15:0], w_lb2_q};
  assign w_mid_next = {r_mid[15:0], w_lb1_q};
  assign w_bot_next = {r_bot[15:0], grayscale_i};

  // Raster position counters; the last pixel of a frame wraps both to zero
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_sample) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // NOTE: line buffers are plain RAM without reset; stale rows are never emitted
  // because window validity is gated by the row/col counters.
  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_lb2[r_col] <= w_lb1_q;
      r_lb1[r_col] <= grayscale_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top <= '0;
      r_mid <= '0;
      r_bot <= '0;
    end else if (w_sample) begin
      r_top <= w_top_next;
      r_mid <= w_mid_next;
      r_bot <= w_bot_next;
    end
  end

  // Output window is loaded only for valid samples so it holds between windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window     <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= w_sample && w_win_ok;
      r_frame_done <= w_sample && w_col_last && w_row_last;
      if (w_sample && w_win_ok) begin
        r_window <= {w_top_next, w_mid_next, w_bot_next};
      end
    end
  end

  assign window_o     = r_window;
  assign valid_o      = r_valid;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: 30x30 frames (continuous, stalled,
// back-to-back, mid-frame reset) and a minimal 3x3 image on a second instance.
module tb_window_3x3_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done;
  logic [7:0]  gray;
  logic [71:0] win;
  logic        valid;
  logic        fdone;

  logic        done3;
  logic [7:0]  gray3;
  logic [71:0] win3;
  logic        valid3;
  logic        fdone3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  window_3x3_gen #(.WIDTH(30), .HEIGHT(30)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .grayscale_i  (gray),
    .done_i       (done),
    .window_o     (win),
    .valid_o      (valid),
    .frame_done_o (fdone)
  );

  window_3x3_gen #(.WIDTH(3), .HEIGHT(3)) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .grayscale_i  (gray3),
    .done_i       (done3),
    .window_o     (win3),
    .valid_o      (valid3),
    .frame_done_o (fdone3)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((30 * r + c) % 256);
  endfunction

  function automatic logic [71:0] win_model(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[71 - 8 * (3 * i + j) -: 8] = pix(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  // Drive one cycle away from the edge, then sample 1 time unit after the edge
  task automatic step(input logic d, input logic [7:0] p);
    done = d;
    gray = p;
    @(posedge clk);
    #1;
  endtask

  // Sends pixels 0..npix-1 of the 30x30 test pattern, optionally stalling
  // 5 cycles after every 7th pixel, and tallies what the DUT produced.
  task automatic run_pixels(input int npix, input bit stall,
                            output int nwin, output int nfd, output int mism,
                            output int first_idx, output logic [71:0] first_w,
                            output logic [71:0] fd_w);
    logic [71:0] held;
    nwin = 0; nfd = 0; mism = 0; first_idx = -1; first_w = '0; fd_w = '0;
    for (int idx = 0; idx < npix; idx++) begin
      int   r;
      int   c;
      logic exp_v;
      logic exp_fd;
      r = idx / 30;
      c = idx % 30;
      exp_v  = (r >= 2) && (c >= 2);
      exp_fd = (idx == 899);
      step(1'b1, pix(r, c));
      if (valid !== exp_v) mism++;
      if (fdone !== exp_fd) mism++;
      if (exp_v && (win !== win_model(r, c))) mism++;
      if (valid === 1'b1) begin
        nwin++;
        if (first_idx < 0) begin
          first_idx = idx;
          first_w   = win;
        end
      end
      if (fdone === 1'b1) begin
        nfd++;
        fd_w = win;
      end
      if (stall && (idx % 7 == 6)) begin
        held = win;
        for (int s = 0; s < 5; s++) begin
          step(1'b0, 8'($urandom_range(0, 255)));
          if (valid !== 1'b0 || fdone !== 1'b0 || win !== held) mism++;
        end
      end
    end
  endtask

  localparam logic [71:0] FIRST_WIN = 72'h00_01_02_1E_1F_20_3C_3D_3E;
  localparam logic [71:0] LAST_WIN  = 72'h45_46_47_63_64_65_81_82_83;

  initial begin
    int          nwin, nfd, mism, first_idx;
    int          nwin2, nfd2, mism2, first_idx2;
    int          nw3;
    logic [71:0] first_w, fd_w, first_w2, fd_w2;

    rst_n = 1'b0;
    done  = 1'b0;
    gray  = 8'h00;
    done3 = 1'b0;
    gray3 = 8'h00;
    #2;
    check("reset_window", win, 72'h0);
    check("reset_valid", 72'(valid), 72'h0);
    check("reset_frame_done", 72'(fdone), 72'h0);
    check("reset_window3", win3, 72'h0);
    #10;
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous frame
    run_pixels(900, 1'b0, nwin, nfd, mism, first_idx, first_w, fd_w);
    check("cont_first_idx", 72'(first_idx), 72'd62);
    check("cont_first_win", first_w, FIRST_WIN);
    check("cont_win_count", 72'(nwin), 72'd784);
    check("cont_fd_count", 72'(nfd), 72'd1);
    check("cont_fd_byte", 72'(fd_w[7:0]), 72'd131);
    check("cont_mismatches", 72'(mism), 72'd0);

    step(1'b0, 8'hAA);
    check("idle_valid", 72'(valid), 72'h0);
    check("idle_hold", win, LAST_WIN);

    // Frame with periodic stalls
    run_pixels(900, 1'b1, nwin, nfd, mism, first_idx, first_w, fd_w);
    check("stall_first_win", first_w, FIRST_WIN);
    check("stall_win_count", 72'(nwin), 72'd784);
    check("stall_fd_count", 72'(nfd), 72'd1);
    check("stall_fd_byte", 72'(fd_w[7:0]), 72'd131);
    check("stall_mismatches", 72'(mism), 72'd0);

    // Two frames back-to-back, no idle cycle between them
    run_pixels(900, 1'b0, nwin, nfd, mism, first_idx, first_w, fd_w);
    run_pixels(900, 1'b0, nwin2, nfd2, mism2, first_idx2, first_w2, fd_w2);
    check("b2b_win_total", 72'(nwin + nwin2), 72'd1568);
    check("b2b_fd_total", 72'(nfd + nfd2), 72'd2);
    check("b2b_f2_first_idx", 72'(first_idx2), 72'd62);
    check("b2b_f2_first_win", first_w2, FIRST_WIN);
    check("b2b_mismatches", 72'(mism + mism2), 72'd0);

    // Mid-frame asynchronous reset, then a complete frame
    run_pixels(400, 1'b0, nwin, nfd, mism, first_idx, first_w, fd_w);
    check("prereset_window", win, win_model(13, 9));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_window", win, 72'h0);
    check("async_rst_valid", 72'(valid), 72'h0);
    check("async_rst_fd", 72'(fdone), 72'h0);
    done = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held_valid", 72'(valid), 72'h0);
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_pixels(900, 1'b0, nwin, nfd, mism, first_idx, first_w, fd_w);
    check("postrst_first_idx", 72'(first_idx), 72'd62);
    check("postrst_first_win", first_w, FIRST_WIN);
    check("postrst_win_count", 72'(nwin), 72'd784);
    check("postrst_fd_byte", 72'(fd_w[7:0]), 72'd131);
    check("postrst_mismatches", 72'(mism), 72'd0);

    // Minimal 3x3 image on the second instance
    done = 1'b0;
    nw3  = 0;
    for (int k = 1; k <= 9; k++) begin
      done3 = 1'b1;
      gray3 = 8'(k);
      @(posedge clk);
      #1;
      if (valid3 === 1'b1) nw3++;
      if (k == 8) check("w3_no_early_valid", 72'(valid3), 72'h0);
    end
    check("w3_window", win3, 72'h01_02_03_04_05_06_07_08_09);
    check("w3_valid", 72'(valid3), 72'h1);
    check("w3_frame_done", 72'(fdone3), 72'h1);
    done3 = 1'b0;
    @(posedge clk);
    #1;
    check("w3_count", 72'(nw3), 72'd1);
    check("w3_idle_valid", 72'({valid3, fdone3}), 72'h0);
    check("w3_idle_hold", win3, 72'h01_02_03_04_05_06_07_08_09);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
